// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed by a byte FIFO.
// Data width, parity and stop bits can be set at runtime; they are latched per frame when the word is popped.
module uart_tx_fifo_cfg #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CNT_W-1:0]             clk_div,
  input  logic [1:0]                   cfg_data_bits,
  input  logic                         cfg_parity_en,
  input  logic                         cfg_parity_odd,
  input  logic                         cfg_stop2,
  input  logic                         tx_en,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [LW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, div_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q, last_idx_q;
  logic             par_en_q, par_bit_q, stop2_q, stop_idx_q;
  logic             tx_q, busy_q, frame_done_q;

  logic [LW-1:0]    level_c;
  logic             full_c, empty_c, push_c, pop_c;
  logic             bit_end_c, stop_end_c, head_par_c;
  logic [7:0]       head_c, mask_c;

  // FIFO status and the pop decision, shared by the pointer and frame logic
  always_comb begin
    level_c    = wr_ptr_q - rd_ptr_q;
    full_c     = (level_c == LW'(FIFO_DEPTH));
    empty_c    = (wr_ptr_q == rd_ptr_q);
    push_c     = in_valid && rst_n && !full_c;
    bit_end_c  = (cnt_q == div_q - CNT_W'(1));
    stop_end_c = (state_q == S_STOP) && bit_end_c && (stop_idx_q == stop2_q);
    pop_c      = rst_n && tx_en && !empty_c && ((state_q == S_IDLE) || stop_end_c);
    head_c     = mem_q[rd_ptr_q[AW-1:0]];
    mask_c     = 8'hFF >> (2'd3 - cfg_data_bits);
    head_par_c = (^(head_c & mask_c)) ^ cfg_parity_odd;
  end

  assign in_ready   = rst_n && !full_c;
  assign fifo_level = level_c;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + LW'(1);
    end
  end

  // Frame sequencer; a pop always starts a new frame, including straight out of STOP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      div_q        <= CNT_W'(1);
      shift_q      <= '0;
      bit_idx_q    <= '0;
      last_idx_q   <= 3'd7;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      stop_idx_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop_c) begin
        state_q      <= S_START;
        cnt_q        <= '0;
        div_q        <= (clk_div == '0) ? CNT_W'(1) : clk_div;
        shift_q      <= head_c;
        bit_idx_q    <= '0;
        last_idx_q   <= 3'(cfg_data_bits) + 3'd4;
        par_en_q     <= cfg_parity_en;
        par_bit_q    <= head_par_c;
        stop2_q      <= cfg_stop2;
        stop_idx_q   <= 1'b0;
        tx_q         <= 1'b0;
        busy_q       <= 1'b1;
        frame_done_q <= (state_q == S_STOP);
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
          end
          S_START: begin
            if (bit_end_c) begin
              cnt_q   <= '0;
              state_q <= S_DATA;
              tx_q    <= shift_q[0];
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (bit_end_c) begin
              cnt_q <= '0;
              if (bit_idx_q == last_idx_q) begin
                if (par_en_q) begin
                  state_q <= S_PARITY;
                  tx_q    <= par_bit_q;
                end else begin
                  state_q    <= S_STOP;
                  tx_q       <= 1'b1;
                  stop_idx_q <= 1'b0;
                end
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                shift_q   <= {1'b0, shift_q[7:1]};
                tx_q      <= shift_q[1];
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_PARITY: begin
            if (bit_end_c) begin
              cnt_q      <= '0;
              state_q    <= S_STOP;
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_STOP: begin
            if (bit_end_c) begin
              cnt_q <= '0;
              if (stop_idx_q == stop2_q) begin
                frame_done_q <= 1'b1;
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
              end else begin
                stop_idx_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Scoreboard bench for uart_tx_fifo_cfg.
// Accepted pushes queue an expected frame; a monitor checks the serial line cycle by cycle.
module tb_uart_tx_fifo_cfg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 32;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] clk_div;
  logic [1:0]    cfg_data_bits;
  logic          cfg_parity_en, cfg_parity_odd, cfg_stop2, tx_en;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [4:0]    fifo_level;
  logic          tx, busy, frame_done;

  uart_tx_fifo_cfg #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
    .tx_en(tx_en), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_level(fifo_level), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         par_en;
    bit         odd;
    int         stops;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     n_total  = 0;
  int     n_bad    = 0;
  int     fd_count = 0;
  bit     in_frame = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic frame_t mkf(input int div, input int nbits, input bit pe, input bit odd,
                                 input int stops);
    frame_t f;
    f.data = 8'h00; f.div = div; f.nbits = nbits; f.par_en = pe; f.odd = odd; f.stops = stops;
    return f;
  endfunction

  task automatic drive_cfg(input frame_t f);
    clk_div        = CW'(f.div);
    cfg_data_bits  = 2'(f.nbits - 5);
    cfg_parity_en  = f.par_en;
    cfg_parity_odd = f.odd;
    cfg_stop2      = (f.stops == 2);
  endtask

  // Called at posedge+1; the frame is expected only if in_ready allowed the push
  task automatic push_word(input logic [7:0] d, input frame_t f);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    acc      = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) begin
      f.data = d;
      exp_q.push_back(f);
    end
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (exp_q.size() == 0 && !in_frame && busy === 1'b0 && tx === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("idle_reached", 32'(ok), 32'd1);
  endtask

  always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

  // Entered on the first negedge where tx is low; checks every cycle of one frame
  task automatic mon_frame();
    frame_t f;
    logic   bits [12];
    int     len, d;
    bit     p, first;
    in_frame = 1'b1;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_frame", 32'd1, 32'd0);
      @(negedge clk);
      in_frame = 1'b0;
      return;
    end
    f = exp_q.pop_front();
    len = 0;
    bits[len] = 1'b0; len++;
    p = f.odd;
    for (int i = 0; i < f.nbits; i++) begin
      bits[len] = f.data[i]; len++;
      p ^= f.data[i];
    end
    if (f.par_en) begin bits[len] = p; len++; end
    for (int s = 0; s < f.stops; s++) begin bits[len] = 1'b1; len++; end
    d = (f.div == 0) ? 1 : f.div;
    first = 1'b1;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < d; c++) begin
        if (!first) @(negedge clk);
        if (!rst_n) begin in_frame = 1'b0; return; end
        check_eq("tx_bit", 32'(tx), 32'(bits[i]));
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        if (!first) check_eq("frame_done_early", 32'(frame_done), 32'd0);
        first = 1'b0;
      end
    end
    @(negedge clk);
    if (!rst_n) begin in_frame = 1'b0; return; end
    check_eq("frame_done_end", 32'(frame_done), 32'd1);
    if (exp_q.size() != 0 && tx_en) begin
      check_eq("b2b_tx", 32'(tx), 32'd0);
      check_eq("b2b_busy", 32'(busy), 32'd1);
    end else begin
      check_eq("idle_tx", 32'(tx), 32'd1);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end
    in_frame = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (rst_n === 1'b1 && tx === 1'b0) mon_frame();
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    frame_t f, fb;
    int     fd0;
    rst_n = 1'b0; tx_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    drive_cfg(mkf(4, 8, 1'b0, 1'b0, 1));
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 8N1, one word
    f = mkf(4, 8, 1'b0, 1'b0, 1);
    drive_cfg(f);
    tx_en = 1'b1;
    fd0 = fd_count;
    push_word(8'hA5, f);
    wait_idle(200);
    check_eq("t1_fd_once", 32'(fd_count - fd0), 32'd1);

    // 7E2
    f = mkf(3, 7, 1'b1, 1'b0, 2);
    drive_cfg(f);
    push_word(8'h55, f);
    wait_idle(200);

    // 5O1, high bits dropped
    f = mkf(2, 5, 1'b1, 1'b1, 1);
    drive_cfg(f);
    push_word(8'hFF, f);
    wait_idle(200);

    // Fill to full with transmission held, then drain back to back
    tx_en = 1'b0;
    f = mkf(2, 8, 1'b0, 1'b0, 1);
    drive_cfg(f);
    for (int i = 0; i < 17; i++) push_word(8'($urandom), f);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_level", 32'(fifo_level), 32'd16);
    fd0 = fd_count;
    tx_en = 1'b1;
    push_word(8'h3C, f);
    wait_idle(1000);
    check_eq("drain_fd_count", 32'(fd_count - fd0), 32'd16);
    check_eq("drain_level", 32'(fifo_level), 32'd0);

    // Config change mid-frame only affects the next frame; clk_div=0 acts as 1
    f  = mkf(3, 8, 1'b0, 1'b0, 1);
    fb = mkf(0, 6, 1'b1, 1'b1, 2);
    drive_cfg(f);
    push_word(8'h96, f);
    push_word(8'h2C, fb);
    repeat (3) begin @(posedge clk); #1; end
    drive_cfg(fb);
    wait_idle(300);

    // Reset in the middle of DATA with three words queued
    f = mkf(4, 8, 1'b0, 1'b0, 1);
    drive_cfg(f);
    for (int i = 0; i < 4; i++) push_word(8'(8'h11 * (i + 1)), f);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    fd0 = fd_count;
    #1;
    check_eq("rst_mid_in_ready_now", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_mid_tx", 32'(tx), 32'd1);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_level", 32'(fifo_level), 32'd0);
    check_eq("rst_mid_in_ready", 32'(in_ready), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check_eq("rst_hold_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_no_frame_done", 32'(fd_count - fd0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    check_eq("rel_level", 32'(fifo_level), 32'd0);
    repeat (20) begin @(posedge clk); #1; end
    check_eq("rel_no_frame_busy", 32'(busy), 32'd0);
    check_eq("rel_no_frame_tx", 32'(tx), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
